neuron_train_ctrl: RTL and testbench

NEURON_TRAIN_CTRL -- requirements
Module: neuron_train_ctrl

---
 rtl/neuron_train_ctrl.sv | 159 +++++++++++++++
 tb/tb_neuron_train_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_train_ctrl.sv
// neuron_train_ctrl: scrambles a neuron, then runs eval/learn epochs over a
// small sample buffer until the summed error drops below threshold or the limit.
module neuron_train_ctrl #(
   parameter int N               = 16,
   parameter int DEPTH           = 8,
   parameter int SCRAMBLE_CYCLES = 32,
   parameter int EPOCH_W         = 8,
   parameter int ZW              = 8,
   localparam int AW             = $clog2(DEPTH),
   localparam int EW             = ZW + AW
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [N-1:0][ZW-1:0]   wr_in,
   input  logic [ZW-1:0]          wr_expected,
   input  logic                   start,
   input  logic                   abort,
   input  logic [AW:0]            sample_count,
   input  logic [EPOCH_W-1:0]     max_epochs,
   input  logic [EW-1:0]          err_threshold,
   output logic                   busy,
   output logic                   done,
   output logic                   converged,
   output logic [EPOCH_W-1:0]     epoch_count,
   output logic [EW-1:0]          epoch_error,
   output logic                   nrn_valid,
   output logic                   nrn_learn,
   output logic [N-1:0][ZW-1:0]   nrn_in,
   output logic [ZW-1:0]          nrn_expected,
   input  logic [ZW-1:0]          nrn_out
);

   localparam int SW = $clog2(SCRAMBLE_CYCLES + 1);
   localparam logic [SW-1:0] SC_LAST = SW'(SCRAMBLE_CYCLES - 1);
   localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_SCRAMBLE, S_EVAL, S_LEARN, S_NEXT, S_FINISH
   } state_t;

   state_t                r_state, w_state_n;
   logic [SW-1:0]         r_scr;
   logic [AW-1:0]         r_idx;
   logic [EW-1:0]         r_acc;
   logic [AW:0]           r_count;
   logic [EPOCH_W-1:0]    r_max;
   logic [EW-1:0]         r_thr;
   logic [EPOCH_W-1:0]    r_epoch;
   logic [EW-1:0]         r_err;
   logic                  r_conv;

   logic [N-1:0][ZW-1:0]  r_buf_in  [DEPTH];
   logic [ZW-1:0]         r_buf_exp [DEPTH];

   logic                  w_start_ok;
   logic                  w_last;
   logic                  w_ep_last;
   logic                  w_conv;
   logic [ZW-1:0]         w_diff;
   logic [EW:0]           w_sum;
   logic [EW-1:0]         w_acc_n;
   logic [AW-1:0]         w_sel;

   assign w_start_ok = start && (sample_count != '0) &&
                       (sample_count <= DEPTH_C) && (max_epochs != '0);
   assign w_last     = ({1'b0, r_idx} + 1'b1) == r_count;
   assign w_ep_last  = (r_epoch + 1'b1) == r_max;
   assign w_conv     = r_acc <= r_thr;
   assign w_diff     = (nrn_expected >= nrn_out) ? nrn_expected - nrn_out
                                                 : nrn_out - nrn_expected;
   assign w_sum      = {1'b0, r_acc} + {{(EW+1-ZW){1'b0}}, w_diff};
   assign w_acc_n    = w_sum[EW] ? '1 : w_sum[EW-1:0];

   always_ff @(posedge clock) begin
      if (wr_en && r_state == S_IDLE) begin
         r_buf_in[wr_addr]  <= wr_in;
         r_buf_exp[wr_addr] <= wr_expected;
      end
   end

   // idx may be stale after an abort, so IDLE forces entry 0
   assign w_sel        = (r_state == S_IDLE || r_state == S_SCRAMBLE) ? '0 : r_idx;
   assign nrn_in       = r_buf_in[w_sel];
   assign nrn_expected = r_buf_exp[w_sel];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      unique case (r_state)
         S_IDLE:     if (w_start_ok) w_state_n = S_SCRAMBLE;
         S_SCRAMBLE: if (abort) w_state_n = S_FINISH;
                     else if (r_scr == SC_LAST) w_state_n = S_EVAL;
         S_EVAL:     w_state_n = abort ? S_FINISH : S_LEARN;
         S_LEARN:    w_state_n = abort ? S_FINISH : S_NEXT;
         S_NEXT:     if (abort) w_state_n = S_FINISH;
                     else if (!w_last) w_state_n = S_EVAL;
                     else if (w_conv || w_ep_last) w_state_n = S_FINISH;
                     else w_state_n = S_EVAL;
         S_FINISH:   w_state_n = S_IDLE;
         default:    w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_scr   <= '0;
         r_idx   <= '0;
         r_acc   <= '0;
         r_count <= '0;
         r_max   <= '0;
         r_thr   <= '0;
         r_epoch <= '0;
         r_err   <= '0;
         r_conv  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: if (w_start_ok) begin
               r_count <= sample_count;
               r_max   <= max_epochs;
               r_thr   <= err_threshold;
               r_epoch <= '0;
               r_idx   <= '0;
               r_acc   <= '0;
               r_conv  <= 1'b0;
               r_scr   <= '0;
            end
            S_SCRAMBLE: r_scr <= r_scr + 1'b1;
            S_EVAL:     r_acc <= w_acc_n;
            S_NEXT: begin
               if (w_last) begin
                  r_err   <= r_acc;
                  r_epoch <= r_epoch + 1'b1;
                  r_acc   <= '0;
                  r_idx   <= '0;
                  if (w_conv && !abort) r_conv <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = r_state != S_IDLE;
   assign done        = r_state == S_FINISH;
   assign converged   = r_conv;
   assign epoch_count = r_epoch;
   assign epoch_error = r_err;
   assign nrn_valid   = r_state != S_SCRAMBLE;
   assign nrn_learn   = (r_state == S_LEARN) && !abort;

endmodule

// File: tb/tb_neuron_train_ctrl.sv
// tb_neuron_train_ctrl: table vectors, corner sequences and random runs
// checked against an epoch-level error model.
module tb_neuron_train_ctrl;

   localparam int N  = 2;
   localparam int DP = 4;
   localparam int SC = 5;
   localparam int ZW = 8;
   localparam int AW = 2;
   localparam int EW = 10;

   logic                 clock, reset_n;
   logic                 wr_en, start, abort;
   logic [AW-1:0]        wr_addr;
   logic [N-1:0][ZW-1:0] wr_in;
   logic [ZW-1:0]        wr_expected;
   logic [AW:0]          sample_count;
   logic [7:0]           max_epochs;
   logic [EW-1:0]        err_threshold;
   logic                 busy, done, converged, nrn_valid, nrn_learn;
   logic [7:0]           epoch_count;
   logic [EW-1:0]        epoch_error;
   logic [N-1:0][ZW-1:0] nrn_in;
   logic [ZW-1:0]        nrn_expected, nrn_out;

   neuron_train_ctrl #(.N(N), .DEPTH(DP), .SCRAMBLE_CYCLES(SC),
                       .EPOCH_W(8), .ZW(ZW)) dut (
      .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_in(wr_in), .wr_expected(wr_expected), .start(start), .abort(abort),
      .sample_count(sample_count), .max_epochs(max_epochs),
      .err_threshold(err_threshold), .busy(busy), .done(done),
      .converged(converged), .epoch_count(epoch_count),
      .epoch_error(epoch_error), .nrn_valid(nrn_valid), .nrn_learn(nrn_learn),
      .nrn_in(nrn_in), .nrn_expected(nrn_expected), .nrn_out(nrn_out));

   initial clock = 0;
   always #5 clock = ~clock;

   // stand-in neuron: constant, perfect, or echo of input 0
   int         mode;
   logic [7:0] cval;
   always_comb begin
      case (mode)
         0:       nrn_out = cval;
         1:       nrn_out = nrn_expected;
         default: nrn_out = nrn_in[0];
      endcase
   end

   logic [N-1:0][ZW-1:0] tb_in  [DP];
   logic [ZW-1:0]        tb_exp [DP];
   int n_pass, n_tot, cyc;

   task automatic chk(input string nm, input longint got, input longint exp);
      n_tot++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
   endtask

   task automatic tick();
      @(posedge clock); #1; cyc++;
   endtask

   task automatic wr(input int a, input int i0, input int i1, input int e);
      wr_en = 1; wr_addr = AW'(a);
      wr_in[0] = 8'(i0); wr_in[1] = 8'(i1); wr_expected = 8'(e);
      tick();
      wr_en = 0;
      tb_in[a][0] = 8'(i0); tb_in[a][1] = 8'(i1); tb_exp[a] = 8'(e);
   endtask

   task automatic go(input int cnt, input int mx, input int thr);
      start = 1; sample_count = 3'(cnt); max_epochs = 8'(mx);
      err_threshold = 10'(thr); cyc = 0;
      tick();
      start = 0;
   endtask

   function automatic int model_err(input int cnt);
      int s, o;
      s = 0;
      for (int i = 0; i < cnt; i++) begin
         o = (mode == 0) ? int'(cval) : (mode == 1) ? int'(tb_exp[i]) : int'(tb_in[i][0]);
         s += (int'(tb_exp[i]) > o) ? int'(tb_exp[i]) - o : o - int'(tb_exp[i]);
      end
      return s;
   endfunction

   task automatic do_case(input string nm, input int cnt, input int mx,
                          input int thr, input int ep, input int err, input int cv);
      int dcyc, flearn, nlearn, oerr;
      dcyc = -1; flearn = -1; nlearn = 0; oerr = 0;
      go(cnt, mx, thr);
      while (cyc < SC + 20 + 3 * DP * mx) begin
         if (nrn_learn) begin
            if (flearn < 0) flearn = cyc;
            if (nrn_in !== tb_in[nlearn % cnt] ||
                nrn_expected !== tb_exp[nlearn % cnt]) oerr++;
            nlearn++;
         end
         if (done) begin dcyc = cyc; break; end
         tick();
      end
      chk({nm, " done_cycle"}, dcyc, SC + 1 + 3 * cnt * ep);
      chk({nm, " first_learn"}, flearn, SC + 2);
      chk({nm, " learn_count"}, nlearn, cnt * ep);
      chk({nm, " learn_order"}, oerr, 0);
      chk({nm, " epoch_count"}, epoch_count, ep);
      chk({nm, " epoch_error"}, epoch_error, err);
      chk({nm, " converged"}, converged, cv);
      tick();
      chk({nm, " idle_after"}, {busy, done, nrn_valid}, 3'b001);
   endtask

   typedef struct {
      string nm;
      int cnt, mx, thr, md, cv_in, ep, err, conv;
   } vec_t;

   vec_t tbl [8];
   int   ndone, nlearn_seen, e, th, c, m;

   initial begin
      tbl[0] = '{"r023",  2, 3, 0,    0, 0,   3, 10,  0};
      tbl[1] = '{"r024",  4, 5, 0,    1, 0,   1, 0,   1};
      tbl[2] = '{"echo4", 4, 4, 0,    2, 0,   4, 271, 0};
      tbl[3] = '{"th_eq", 3, 6, 16,   2, 0,   1, 16,  1};
      tbl[4] = '{"th_lo", 3, 2, 15,   2, 0,   2, 16,  0};
      tbl[5] = '{"c1_no", 1, 1, 3,    0, 0,   1, 4,   0};
      tbl[6] = '{"c1_eq", 1, 1, 4,    0, 0,   1, 4,   1};
      tbl[7] = '{"hi",    4, 2, 1000, 0, 255, 1, 655, 1};

      n_pass = 0; n_tot = 0; cyc = 0; mode = 0; cval = 0;
      reset_n = 0; wr_en = 0; start = 0; abort = 0; wr_addr = 0;
      wr_in = '0; wr_expected = 0; sample_count = 0; max_epochs = 0;
      err_threshold = 0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst conv", converged, 0);
      chk("rst epoch_count", epoch_count, 0);
      chk("rst epoch_error", epoch_error, 0);
      chk("rst valid_learn", {nrn_valid, nrn_learn}, 2'b10);
      reset_n = 1;
      tick();

      wr(0, 8'h5a, 8'h11, 8'h33);
      chk("wr_visible in", nrn_in, {8'h11, 8'h5a});
      chk("wr_visible exp", nrn_expected, 8'h33);

      wr(0, 10, 1, 4);
      wr(1, 6, 2, 6);
      wr(2, 90, 3, 100);
      wr(3, 0, 4, 255);
      foreach (tbl[i]) begin
         mode = tbl[i].md; cval = 8'(tbl[i].cv_in);
         do_case(tbl[i].nm, tbl[i].cnt, tbl[i].mx, tbl[i].thr,
                 tbl[i].ep, tbl[i].err, tbl[i].conv);
      end

      // abort on 2nd EVAL; wr_en and start during the run must be ignored
      mode = 0; cval = 0;
      go(4, 3, 0);
      chk("scr valid", nrn_valid, 0);
      wr_en = 1; wr_addr = 0; wr_in = '1; wr_expected = 8'hff; start = 1;
      tick();
      wr_en = 0; start = 0;
      while (cyc < SC + 4) tick();
      abort = 1;
      chk("ab eval valid", nrn_valid, 1);
      tick();
      abort = 0;
      chk("ab done", done, 1);
      ndone = 0; nlearn_seen = 0;
      repeat (6) begin
         tick();
         ndone += int'(done); nlearn_seen += int'(nrn_learn);
      end
      chk("ab extra_done", ndone, 0);
      chk("ab learn", nlearn_seen, 0);
      chk("ab epoch_count", epoch_count, 0);
      chk("ab epoch_error", epoch_error, 655);
      chk("ab conv", converged, 0);
      chk("ab buf_kept", nrn_in, tb_in[0]);

      // abort during LEARN masks the learn strobe that cycle
      go(2, 3, 0);
      while (cyc < SC + 2) tick();
      chk("abl learn_pre", nrn_learn, 1);
      abort = 1; #1;
      chk("abl learn_mask", nrn_learn, 0);
      tick();
      abort = 0;
      chk("abl done", done, 1);
      chk("abl epoch_count", epoch_count, 0);
      tick();

      // abort coinciding with a converging epoch end commits results
      go(1, 5, 10);
      while (cyc < SC + 3) tick();
      abort = 1;
      tick();
      abort = 0;
      chk("abe done", done, 1);
      chk("abe epoch_count", epoch_count, 1);
      chk("abe epoch_error", epoch_error, 4);
      chk("abe conv", converged, 0);
      tick();

      // reset mid-LEARN
      go(2, 3, 0);
      while (cyc < SC + 2) tick();
      chk("rl learn_pre", nrn_learn, 1);
      #2 reset_n = 0;
      #1;
      chk("rl learn", nrn_learn, 0);
      chk("rl outs", {busy, done, converged, nrn_valid}, 4'b0001);
      chk("rl epoch_count", epoch_count, 0);
      chk("rl epoch_error", epoch_error, 0);
      tick();
      reset_n = 1;
      ndone = 0;
      repeat (4) begin tick(); ndone += int'(done) + int'(busy); end
      chk("rl idle_wait", ndone, 0);
      do_case("rl rerun", 2, 3, 0, 3, 10, 0);

      // out-of-range starts
      go(0, 3, 0);
      chk("cnt0 busy", busy, 0);
      go(DP + 1, 3, 0);
      chk("cntD1 busy", busy, 0);
      go(2, 0, 0);
      chk("mx0 busy", busy, 0);

      // error at its ceiling: every |diff| = 255 over a full buffer
      for (int i = 0; i < DP; i++) wr(i, 0, i, 255);
      mode = 0; cval = 0;
      do_case("sat", DP, 1, 0, 1, 255 * DP, 0);

      // random runs checked against the epoch model
      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < DP; i++)
            wr(i, $urandom_range(255), $urandom_range(255), $urandom_range(255));
         mode = $urandom_range(2); cval = 8'($urandom_range(255));
         c = $urandom_range(DP, 1); m = $urandom_range(4, 1);
         th = $urandom_range(600);
         e = model_err(c);
         do_case($sformatf("rnd%0d", r), c, m, th, (e <= th) ? 1 : m, e,
                 (e <= th) ? 1 : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
